gemm_ex_ctl: RTL and testbench

//  Execution sequencer for the GEMM engine: runs a runtime-sized two-level loop (row dc outer, inner ic).

---
 rtl/gemm_ctl_pkg.sv | 18 +
 rtl/gemm_ex_ctl_loop_ctr.sv | 30 +++
 rtl/gemm_ex_ctl.sv | 150 +++++++++++++++
 tb/tb_gemm_ex_ctl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_ctl_pkg.sv
// Shared types and default sizing for the GEMM execution sequencer.
package gemm_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KINIT,
        EXEC,
        KWAIT,
        DRAIN
    } ctl_st_e;

    localparam int unsigned DEF_DC_W    = 3;
    localparam int unsigned DEF_IC_W    = 4;
    localparam int unsigned DEF_IA_W    = 7;
    localparam int unsigned DEF_FIN_DLY = 4;
    localparam int unsigned PERF_W      = 32;

endpackage

// File: rtl/gemm_ex_ctl_loop_ctr.sv
// Wrapping loop counter: counts 0..fin while enabled; next pulses on the wrap step.
module loop_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         en,
    input  logic [W-1:0] fin,
    output logic [W-1:0] cnt,
    output logic         last,
    output logic         next
);

    always_comb begin
        last = (cnt == fin);
        next = en && last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/gemm_ex_ctl.sv
// GEMM execution sequencer: dc-outer / ic-inner loop driving the MAC array.
// Optional perf counters enabled by defining GEMM_EX_CTL_PERF_EN.
module gemm_ex_ctl
    import gemm_ctl_pkg::*;
#(
    parameter int unsigned DC_W    = DEF_DC_W,
    parameter int unsigned IC_W    = DEF_IC_W,
    parameter int unsigned IA_W    = DEF_IA_W,
    parameter int unsigned FIN_DLY = DEF_FIN_DLY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_init,
    input  logic [DC_W-1:0] dc_num,
    input  logic [IC_W-1:0] ic_num,
    input  logic            out_busy,
    input  logic            outr,
    output logic            busy,
    output logic            k_init,
    output logic            exec,
    output logic [IA_W-1:0] ia,
    output logic [IC_W-1:0] wa,
    output logic            k_fin,
    output logic            s_fin
`ifdef GEMM_EX_CTL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_exec,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam int unsigned DLY_W = $clog2(FIN_DLY + 1);

    if (IA_W < DC_W + IC_W) begin : g_bad_ia_w
        $error("gemm_ex_ctl: IA_W must be >= DC_W + IC_W");
    end
    if (FIN_DLY < 1) begin : g_bad_fin_dly
        $error("gemm_ex_ctl: FIN_DLY must be >= 1");
    end

    ctl_st_e         state, state_nx;
    logic [DC_W-1:0] dc_num_q, dc;
    logic [IC_W-1:0] ic_num_q, ic;
    logic            dc_last, dc_wrap, ic_last, ic_wrap;
    logic [IA_W-1:0] base_q;
    logic [DLY_W-1:0] dly_q;
    logic            k_fin_q;
    logic            accept, in_exec;

    assign accept  = (state == IDLE) && s_init;
    assign in_exec = (state == EXEC);

    loop_ctr #(.W(IC_W)) u_ic_ctr (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .en    (in_exec),
        .fin   (ic_num_q),
        .cnt   (ic),
        .last  (ic_last),
        .next  (ic_wrap)
    );

    // dc steps at the end of every kernel; wrapping marks the final kernel.
    loop_ctr #(.W(DC_W)) u_dc_ctr (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .en    (ic_wrap),
        .fin   (dc_num_q),
        .cnt   (dc),
        .last  (dc_last),
        .next  (dc_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (s_init) state_nx = KINIT;
            KINIT:   state_nx = EXEC;
            EXEC:    if (ic_last) state_nx = dc_last ? DRAIN : KWAIT;
            // The k_fin cycle lives here; out_busy low makes it the k_init cycle too.
            KWAIT:   if (!out_busy) state_nx = EXEC;
            DRAIN:   if ((dly_q == '0) && !outr) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        k_init = (state == KINIT) || ((state == KWAIT) && !out_busy);
        exec   = in_exec;
        k_fin  = k_fin_q;
        s_fin  = (state == DRAIN) && (dly_q == '0) && !outr;
        ia     = in_exec ? base_q + IA_W'(ic) : '0;
        wa     = in_exec ? ic : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_num_q <= '0;
            ic_num_q <= '0;
            base_q   <= '0;
            dly_q    <= '0;
            k_fin_q  <= 1'b0;
        end else begin
            k_fin_q <= ic_wrap;
            if (accept) begin
                dc_num_q <= dc_num;
                ic_num_q <= ic_num;
                base_q   <= '0;
            end else if (ic_wrap) begin
                // Strided base replaces dc*(ic_num+1).
                base_q <= dc_last ? '0 : base_q + IA_W'(ic_num_q) + IA_W'(1);
            end
            if (dc_wrap) begin
                dly_q <= DLY_W'(FIN_DLY);
            end else if ((state == DRAIN) && (dly_q != '0)) begin
                dly_q <= dly_q - DLY_W'(1);
            end
        end
    end

`ifdef GEMM_EX_CTL_PERF_EN
    logic stall;
    assign stall = ((state == KWAIT) && out_busy) || ((state == DRAIN) && outr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_exec  <= '0;
            perf_stall <= '0;
        end else if (accept) begin
            perf_exec  <= '0;
            perf_stall <= '0;
        end else begin
            if (in_exec && !(&perf_exec)) perf_exec <= perf_exec + PERF_W'(1);
            if (stall && !(&perf_stall)) perf_stall <= perf_stall + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gemm_ex_ctl.sv
// Directed bench for gemm_ex_ctl; define GEMM_EX_CTL_PERF_EN to cover perf counters.
module tb_gemm_ex_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_init;
    logic [2:0] dc_num;
    logic [3:0] ic_num;
    logic       out_busy;
    logic       outr;
    logic       busy, k_init, exec, k_fin, s_fin;
    logic [6:0] ia;
    logic [3:0] wa;
`ifdef GEMM_EX_CTL_PERF_EN
    logic [31:0] perf_exec, perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic       kinit_tr [64], exec_tr [64], kfin_tr [64], sfin_tr [64], busy_tr [64];
    logic [6:0] ia_tr [64];
    logic [3:0] wa_tr [64];
    logic       kinit_ex [64], exec_ex [64], kfin_ex [64], sfin_ex [64], busy_ex [64];
    int         ia_ex [64], wa_ex [64];

    logic [15:0] outs;
    assign outs = {busy, k_init, exec, k_fin, s_fin, ia, wa};

    always #5 clk = ~clk;

    gemm_ex_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .s_init   (s_init),
        .dc_num   (dc_num),
        .ic_num   (ic_num),
        .out_busy (out_busy),
        .outr     (outr),
        .busy     (busy),
        .k_init   (k_init),
        .exec     (exec),
        .ia       (ia),
        .wa       (wa),
        .k_fin    (k_fin),
        .s_fin    (s_fin)
`ifdef GEMM_EX_CTL_PERF_EN
        ,
        .perf_exec  (perf_exec),
        .perf_stall (perf_stall)
`endif
    );

    // Cycle 0 pulses s_init with the real bounds; other cycles drive decoy bounds.
    task automatic run_set(input int ncyc, input int dcn, input int icn, input int bz_lo,
                           input int bz_hi, input int outr_to, input int ri_a, input int ri_b);
        for (int c = 0; c < ncyc; c++) begin
            s_init   = (c == 0) || (c == ri_a) || (c == ri_b);
            dc_num   = (c == 0) ? 3'(dcn) : 3'd1;
            ic_num   = (c == 0) ? 4'(icn) : 4'd2;
            out_busy = (c >= bz_lo) && (c <= bz_hi);
            outr     = (c < outr_to);
            @(negedge clk);
            kinit_tr[c] = k_init;
            exec_tr[c]  = exec;
            kfin_tr[c]  = k_fin;
            sfin_tr[c]  = s_fin;
            busy_tr[c]  = busy;
            ia_tr[c]    = ia;
            wa_tr[c]    = wa;
            @(posedge clk);
            #1;
        end
        s_init   = 1'b0;
        out_busy = 1'b0;
        outr     = 1'b0;
    endtask

    task automatic clear_exp();
        for (int c = 0; c < 64; c++) begin
            kinit_ex[c] = 0; exec_ex[c] = 0; kfin_ex[c] = 0; sfin_ex[c] = 0; busy_ex[c] = 0;
            ia_ex[c] = 0; wa_ex[c] = 0;
        end
    endtask

    task automatic add_kernel(input int k, input int ki, input int kf, input int icn);
        kinit_ex[ki] = 1;
        kfin_ex[kf]  = 1;
        for (int j = 0; j <= icn; j++) begin
            exec_ex[ki + 1 + j] = 1;
            ia_ex[ki + 1 + j]   = k * (icn + 1) + j;
            wa_ex[ki + 1 + j]   = j;
        end
    endtask

    task automatic set_end(input int sf);
        sfin_ex[sf] = 1;
        for (int c = 1; c <= sf; c++) busy_ex[c] = 1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h want 0000", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        s_init = 1'b1; dc_num = 3'd3; ic_num = 4'd7;
        @(posedge clk);
        #1;
        s_init = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (exec !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_exec: exec=%b want 1", exec);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_exec: outputs=%h want 0000", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if (outs !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: outputs=%h want 0000", c, outs);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_exp();
        add_kernel(0, 1, 10, 7);
        add_kernel(1, 10, 19, 7);
        add_kernel(2, 19, 28, 7);
        add_kernel(3, 28, 37, 7);
        set_end(41);
        run_set(50, 3, 7, 99, 99, 0, -1, -1);
        for (int c = 0; c < 50; c++) begin
            n_tests++;
            if ({kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c]} !==
                {kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c], busy_ex[c]} ||
                (exec_ex[c] && (ia_tr[c] !== 7'(ia_ex[c]) || wa_tr[c] !== 4'(wa_ex[c])))) begin
                n_fail++;
                $display("FAIL basic cyc %0d: ki/ex/kf/sf/bz=%b%b%b%b%b ia=%0d wa=%0d want %b%b%b%b%b ia=%0d wa=%0d",
                         c, kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c],
                         ia_tr[c], wa_tr[c], kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c],
                         busy_ex[c], ia_ex[c], wa_ex[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_exp();
        add_kernel(0, 1, 10, 7);
        add_kernel(1, 15, 24, 7);
        add_kernel(2, 24, 33, 7);
        add_kernel(3, 33, 42, 7);
        set_end(46);
        run_set(55, 3, 7, 10, 14, 0, -1, -1);
        for (int c = 0; c < 55; c++) begin
            n_tests++;
            if ({kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c]} !==
                {kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c], busy_ex[c]} ||
                (exec_ex[c] && (ia_tr[c] !== 7'(ia_ex[c]) || wa_tr[c] !== 4'(wa_ex[c])))) begin
                n_fail++;
                $display("FAIL backpressure cyc %0d: ki/ex/kf/sf/bz=%b%b%b%b%b ia=%0d wa=%0d want %b%b%b%b%b ia=%0d wa=%0d",
                         c, kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c],
                         ia_tr[c], wa_tr[c], kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c],
                         busy_ex[c], ia_ex[c], wa_ex[c]);
            end
        end
    endtask

`ifdef GEMM_EX_CTL_PERF_EN
    task automatic test_perf();
        n_tests++;
        if (perf_exec !== 32'd32) begin
            n_fail++;
            $display("FAIL perf_exec: got %0d want 32", perf_exec);
        end
        n_tests++;
        if (perf_stall !== 32'd5) begin
            n_fail++;
            $display("FAIL perf_stall: got %0d want 5", perf_stall);
        end
    endtask
`endif

    task automatic test_minimal();
        int nsf;
        clear_exp();
        add_kernel(0, 1, 3, 0);
        set_end(20);
        run_set(25, 0, 0, 99, 99, 20, -1, -1);
        nsf = 0;
        for (int c = 0; c < 25; c++) begin
            if (sfin_tr[c] === 1'b1) nsf++;
            n_tests++;
            if ({kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c]} !==
                {kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c], busy_ex[c]} ||
                (exec_ex[c] && (ia_tr[c] !== 7'(ia_ex[c]) || wa_tr[c] !== 4'(wa_ex[c])))) begin
                n_fail++;
                $display("FAIL minimal cyc %0d: ki/ex/kf/sf/bz=%b%b%b%b%b ia=%0d wa=%0d want %b%b%b%b%b ia=%0d wa=%0d",
                         c, kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c],
                         ia_tr[c], wa_tr[c], kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c],
                         busy_ex[c], ia_ex[c], wa_ex[c]);
            end
        end
        n_tests++;
        if (nsf != 1) begin
            n_fail++;
            $display("FAIL minimal_sfin_count: got %0d want 1", nsf);
        end
    endtask

    task automatic test_reinit_ignored();
        int nsf;
        clear_exp();
        add_kernel(0, 1, 10, 7);
        add_kernel(1, 10, 19, 7);
        add_kernel(2, 19, 28, 7);
        add_kernel(3, 28, 37, 7);
        set_end(41);
        run_set(50, 3, 7, 99, 99, 0, 5, 41);
        nsf = 0;
        for (int c = 0; c < 50; c++) begin
            if (sfin_tr[c] === 1'b1) nsf++;
            n_tests++;
            if ({kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c]} !==
                {kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c], busy_ex[c]} ||
                (exec_ex[c] && (ia_tr[c] !== 7'(ia_ex[c]) || wa_tr[c] !== 4'(wa_ex[c])))) begin
                n_fail++;
                $display("FAIL reinit cyc %0d: ki/ex/kf/sf/bz=%b%b%b%b%b ia=%0d wa=%0d want %b%b%b%b%b ia=%0d wa=%0d",
                         c, kinit_tr[c], exec_tr[c], kfin_tr[c], sfin_tr[c], busy_tr[c],
                         ia_tr[c], wa_tr[c], kinit_ex[c], exec_ex[c], kfin_ex[c], sfin_ex[c],
                         busy_ex[c], ia_ex[c], wa_ex[c]);
            end
        end
        n_tests++;
        if (nsf != 1) begin
            n_fail++;
            $display("FAIL reinit_sfin_count: got %0d want 1", nsf);
        end
    endtask

    initial begin
        rst      = 1'b0;
        s_init   = 1'b0;
        dc_num   = 3'd0;
        ic_num   = 4'd0;
        out_busy = 1'b0;
        outr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
`ifdef GEMM_EX_CTL_PERF_EN
        test_perf();
`endif
        test_minimal();
        test_reinit_ignored();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
